// File: rtl/parity_pkg.sv
// Shared widths, stage payload layouts and the nibble-XOR helper for the 9-bit parity checker.
package parity_pkg;

  localparam int DATA_W  = 8;
  localparam int WORD_W  = 9;
  localparam int PAR_BIT = 8;

  typedef struct packed {
    logic              p_hi;
    logic              p_lo;
    logic [WORD_W-1:0] word;
  } s1_t;

  typedef struct packed {
    logic              perr;
    logic [DATA_W-1:0] data;
  } s2_t;

  function automatic logic xor4(input logic [3:0] a);
    return ^a;
  endfunction

endpackage

// File: rtl/parity_pipe_stage.sv
// One valid/ready register slice; ready depends only on local occupancy and the downstream ready.
module parity_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/parity9_checker.sv
// Two-stage parity checker: stage 1 folds the data nibbles, stage 2 resolves the error flag.
module parity9_checker
  import parity_pkg::*;
#(
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  input  logic              clr_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_sticky
);

  localparam logic ODD = (ODD_PARITY != 0);

  s1_t  s1_in, s1_q;
  s2_t  s2_in, s2_q;
  logic [$bits(s1_t)-1:0] s1_bits;
  logic [$bits(s2_t)-1:0] s2_bits;
  logic s1_valid, s2_ready;
  logic err_xfer;

  assign s1_in.p_hi = xor4(in_data[7:4]);
  assign s1_in.p_lo = xor4(in_data[3:0]);
  assign s1_in.word = in_data;

  parity_pipe_stage #(.W($bits(s1_t))) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_bits)
  );

  assign s1_q       = s1_t'(s1_bits);
  assign s2_in.data = s1_q.word[DATA_W-1:0];
  assign s2_in.perr = s1_q.p_lo ^ s1_q.p_hi ^ s1_q.word[PAR_BIT] ^ ODD;

  parity_pipe_stage #(.W($bits(s2_t))) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_bits)
  );

  assign s2_q     = s2_t'(s2_bits);
  assign out_data = s2_q.data;
  assign out_perr = s2_q.perr;

  assign err_xfer = out_valid && out_ready && out_perr;

  // Clear takes priority but still counts an error delivered on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (clr_err) begin
      err_count  <= err_xfer ? CNT_W'(1) : '0;
      err_sticky <= err_xfer;
    end else if (err_xfer) begin
      if (err_count != '1) err_count <= err_count + CNT_W'(1);
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_parity9_checker.sv
// Directed checks on an even-parity 4-bit-counter instance and an odd-parity instance.
module tb_parity9_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_perr, a_clr_err, a_err_sticky;
  logic [8:0] a_in_data;
  logic [7:0] a_out_data;
  logic [3:0] a_err_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_perr, b_clr_err, b_err_sticky;
  logic [8:0]  b_in_data;
  logic [7:0]  b_out_data;
  logic [15:0] b_err_count;

  int n_checks = 0;
  int n_pass   = 0;

  parity9_checker #(.ODD_PARITY(0), .CNT_W(4)) u_dut_even (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_perr(a_out_perr),
    .clr_err(a_clr_err), .err_count(a_err_count), .err_sticky(a_err_sticky)
  );

  parity9_checker #(.ODD_PARITY(1), .CNT_W(16)) u_dut_odd (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_perr(b_out_perr),
    .clr_err(b_clr_err), .err_count(b_err_count), .err_sticky(b_err_sticky)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [8:0] sb[$];
  logic [8:0] exp_w;
  int         n_in, n_out, n_err;
  logic       in_x, out_x;

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1; a_clr_err = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1; b_clr_err = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_out_valid", 32'(a_out_valid), 0);
    check("rst_out_data", 32'(a_out_data), 0);
    check("rst_err_count", 32'(a_err_count), 0);
    check("rst_err_sticky", 32'(a_err_sticky), 0);
    rst_n = 1'b1;
    check("rel_in_ready", 32'(a_in_ready), 1);

    // Even parity, full throughput
    a_in_valid = 1'b1; a_in_data = 9'h0FF;
    step();
    a_in_data = 9'h1FF;
    step();
    a_in_valid = 1'b0;
    check("t2_w0_valid", 32'(a_out_valid), 1);
    check("t2_w0_data", 32'(a_out_data), 'hFF);
    check("t2_w0_perr", 32'(a_out_perr), 0);
    step();
    check("t2_w1_data", 32'(a_out_data), 'hFF);
    check("t2_w1_perr", 32'(a_out_perr), 1);
    check("t2_cnt_before", 32'(a_err_count), 0);
    step();
    check("t2_drained", 32'(a_out_valid), 0);
    check("t2_err_count", 32'(a_err_count), 1);
    check("t2_err_sticky", 32'(a_err_sticky), 1);

    // Backpressure: only two words fit
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 9'h001;
    step();
    check("t3_ready_one", 32'(a_in_ready), 1);
    a_in_data = 9'h002;
    step();
    check("t3_full_ready", 32'(a_in_ready), 0);
    a_in_data = 9'h003;
    step();
    check("t3_blocked_ready", 32'(a_in_ready), 0);
    check("t3_hold_valid", 32'(a_out_valid), 1);
    check("t3_hold_data", 32'(a_out_data), 'h01);
    step();
    check("t3_hold_data2", 32'(a_out_data), 'h01);
    check("t3_hold_perr2", 32'(a_out_perr), 1);
    a_out_ready = 1'b1;
    #1;
    check("t3_ready_comb", 32'(a_in_ready), 1);
    step();
    a_in_valid = 1'b0;
    check("t3_d02_valid", 32'(a_out_valid), 1);
    check("t3_d02", 32'(a_out_data), 'h02);
    step();
    check("t3_d03", 32'(a_out_data), 'h03);
    check("t3_d03_perr", 32'(a_out_perr), 0);
    step();
    check("t3_no_dup", 32'(a_out_valid), 0);
    check("t3_err_count", 32'(a_err_count), 3);

    // Clear alone, then saturation
    a_clr_err = 1'b1;
    step();
    a_clr_err = 1'b0;
    check("t4_clr_count", 32'(a_err_count), 0);
    check("t4_clr_sticky", 32'(a_err_sticky), 0);
    check("t4_clr_pipe", 32'(a_out_valid), 0);
    a_in_valid = 1'b1; a_in_data = 9'h001;
    for (int i = 0; i < 20; i++) step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("t4_saturated", 32'(a_err_count), 'hF);
    check("t4_sticky", 32'(a_err_sticky), 1);

    // Clear together with an erroneous transfer
    a_in_valid = 1'b1; a_in_data = 9'h001;
    step();
    a_in_valid = 1'b0;
    step();
    check("t5_err_present", 32'(a_out_perr & a_out_valid), 1);
    a_clr_err = 1'b1;
    step();
    check("t5_clr_xfer_count", 32'(a_err_count), 1);
    check("t5_clr_xfer_sticky", 32'(a_err_sticky), 1);
    step();
    a_clr_err = 1'b0;
    check("t5_clr_count", 32'(a_err_count), 0);
    check("t5_clr_sticky", 32'(a_err_sticky), 0);

    // Mid-stream asynchronous reset
    a_in_valid = 1'b1; a_in_data = 9'h001;
    step();
    a_in_valid = 1'b0;
    step(); step();
    check("t1_pre_count", 32'(a_err_count), 1);
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 9'h0AA;
    step();
    a_in_data = 9'h155;
    step();
    a_in_valid = 1'b0;
    check("t1_full_valid", 32'(a_out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_valid", 32'(a_out_valid), 0);
    check("t1_async_data", 32'(a_out_data), 0);
    check("t1_async_count", 32'(a_err_count), 0);
    check("t1_async_sticky", 32'(a_err_sticky), 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    check("t1_rel_ready", 32'(a_in_ready), 1);
    step();
    check("t1_discarded", 32'(a_out_valid), 0);

    // Odd parity directed
    b_in_valid = 1'b1; b_in_data = 9'h000;
    step();
    b_in_data = 9'h100;
    step();
    b_in_valid = 1'b0;
    check("t6_w0_data", 32'(b_out_data), 0);
    check("t6_w0_perr", 32'(b_out_perr), 1);
    step();
    check("t6_w1_valid", 32'(b_out_valid), 1);
    check("t6_w1_perr", 32'(b_out_perr), 0);
    step();
    check("t6_odd_count", 32'(b_err_count), 1);

    // Random stalls against a reference XOR model
    n_in = 0; n_out = 0; n_err = 1;
    for (int c = 0; c < 400; c++) begin
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_data   = 9'($urandom);
      b_out_ready = ($urandom_range(0, 2) != 0);
      #1;
      in_x  = b_in_valid & b_in_ready;
      out_x = b_out_valid & b_out_ready;
      if (out_x) begin
        if (sb.size() == 0) begin
          check("t6_unexpected_out", 1, 0);
        end else begin
          exp_w = sb.pop_front();
          check("t6_sb_data", 32'(b_out_data), 32'(exp_w[7:0]));
          check("t6_sb_perr", 32'(b_out_perr), 32'(exp_w[8]));
          if (exp_w[8]) n_err++;
        end
        n_out++;
      end
      if (in_x) begin
        sb.push_back({~(^b_in_data), b_in_data[7:0]});
        n_in++;
      end
      step();
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      #1;
      if (b_out_valid) begin
        exp_w = sb.pop_front();
        check("t6_drain_data", 32'(b_out_data), 32'(exp_w[7:0]));
        check("t6_drain_perr", 32'(b_out_perr), 32'(exp_w[8]));
        if (exp_w[8]) n_err++;
        n_out++;
      end
      step();
    end
    check("t6_sb_empty", 32'(sb.size()), 0);
    check("t6_in_eq_out", 32'(n_out), 32'(n_in));
    check("t6_err_total", 32'(b_err_count), 32'(n_err));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
